// File: rtl/bounce_generator_if.sv
// Bounce generator port bundle: clean level in, bouncing level out.
// enable/clean_in driven by master; bounce_out/busy driven by slave.
interface bounce_generator_if;
  logic enable;
  logic clean_in;
  logic bounce_out;
  logic busy;

  modport master (
    output enable,
    output clean_in,
    input  bounce_out,
    input  busy
  );

  modport slave (
    input  enable,
    input  clean_in,
    output bounce_out,
    output busy
  );
endinterface

// File: rtl/bounce_generator.sv
// Timed Moore FSM turning a clean level into a contact-bounce waveform.
// Ports: clk, rst (async active-low), io.slave {enable, clean_in,
// bounce_out, busy}. Optional macro BOUNCE_LFSR_EN jitters hold times.
module bounce_generator #(
  parameter int NUM_GLITCH = 2,
  parameter int GAP_LEN    = 1,
  parameter int GLITCH_LEN = 1,
  parameter int SETTLE_LEN = 8,
  parameter int TW         = 8
) (
  input  logic              clk,
  input  logic              rst,
  bounce_generator_if.slave io
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    NEW_HOLD = 2'd1,
    OLD_HOLD = 2'd2,
    SETTLE   = 2'd3
  } state_t;

  localparam logic [3:0]    NG     = 4'(NUM_GLITCH);
  localparam logic [TW-1:0] GAP_T  = TW'(GAP_LEN);
  localparam logic [TW-1:0] GLT_T  = TW'(GLITCH_LEN);
  localparam logic [TW-1:0] SET_T  = TW'(SETTLE_LEN);
  localparam logic [TW-1:0] ONE_T  = TW'(1);

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          bo_q, bo_d;
  logic          busy_q, busy_d;

  logic [TW-1:0] gap_load;
  logic [TW-1:0] glt_load;
  logic          expire;

`ifdef BOUNCE_LFSR_EN
  logic [7:0] lfsr_q;
  logic       lfsr_fb;

  // Fibonacci taps 8,6,5,4 on a left-shifting register
  assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5]
                 ^ lfsr_q[4] ^ lfsr_q[3];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_fb};
    end
  end

  assign gap_load = GAP_T
    + {{(TW-2){1'b0}}, lfsr_q[1:0]};
  assign glt_load = GLT_T
    + {{(TW-2){1'b0}}, lfsr_q[1:0]};
`else
  assign gap_load = GAP_T;
  assign glt_load = GLT_T;
`endif

  // Timer is reloaded on every state entry, so it never wraps
  assign expire = (timer_q == ONE_T);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      bo_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      bo_q    <= bo_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    bo_d    = bo_q;
    busy_d  = busy_q;

    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (!io.enable) begin
          level_d = io.clean_in;
          bo_d    = io.clean_in;
        end else if (io.clean_in != level_q) begin
          level_d = io.clean_in;
          bo_d    = io.clean_in;
          busy_d  = 1'b1;
          cnt_d   = NG;
          if (NG != 4'd0) begin
            state_d = NEW_HOLD;
            timer_d = gap_load;
          end else begin
            state_d = SETTLE;
            timer_d = SET_T;
          end
        end
      end

      NEW_HOLD: begin
        if (expire) begin
          state_d = OLD_HOLD;
          bo_d    = ~level_q;
          timer_d = glt_load;
          cnt_d   = cnt_q - 4'd1;
        end else begin
          timer_d = timer_q - ONE_T;
        end
      end

      OLD_HOLD: begin
        if (expire) begin
          bo_d = level_q;
          // cnt already counts this excursion
          if (cnt_q != 4'd0) begin
            state_d = NEW_HOLD;
            timer_d = gap_load;
          end else begin
            state_d = SETTLE;
            timer_d = SET_T;
          end
        end else begin
          timer_d = timer_q - ONE_T;
        end
      end

      SETTLE: begin
        if (expire) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          timer_d = timer_q - ONE_T;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign io.bounce_out = bo_q;
  assign io.busy       = busy_q;

endmodule
